// File: rtl/csr_spi_slave_pkg.sv
// Shared constants for the SPI control/status register file: address map,
// command-byte layout, status word fields and the transaction FSM encoding.
package csr_spi_slave_pkg;

  localparam int         NUM_REGS_DEF    = 16;
  localparam logic [6:0] STATUS_ADDR_DEF = 7'h7F;

  localparam logic [6:0] CSR_CTRL    = 7'h00;
  localparam logic [6:0] CSR_VCOM    = 7'h01;
  localparam logic [6:0] CSR_PWR_SEQ = 7'h02;
  localparam logic [6:0] CSR_TIMING  = 7'h03;

  // Command byte: bit 7 selects write, bits 6:0 hold the start address.
  localparam int CMD_WR_BIT = 7;

  localparam int STAT_POK_BIT        = 7;
  localparam int STAT_CALIB_DONE_BIT = 6;
  localparam int STAT_ERROR_BIT      = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } spi_state_e;

endpackage

// File: rtl/csr_spi_slave_if.sv
// SPI pin bundle between host (master) and the register file (slave).
// Lines are already synchronised to clk; there is no handshake beyond cs/sck.
interface csr_spi_slave_if;
  logic spi_cs;
  logic spi_sck;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_cs, output spi_sck, output spi_mosi, input spi_miso);
  modport slave  (input spi_cs, input spi_sck, input spi_mosi, output spi_miso);
endinterface

// File: rtl/csr_spi_slave_edge_shift.sv
// SPI mode-0 bit engine: SCK edge detect, 3-bit counter, receive/transmit
// shift registers and the registered MISO output.
module csr_spi_slave_edge_shift (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_i,
  input  logic       sck_i,
  input  logic       mosi_i,
  input  logic       clr_cnt_i,
  input  logic       shift_en_i,
  input  logic       tx_load_i,
  input  logic [7:0] tx_data_i,
  output logic       byte_done_o,
  output logic [7:0] rx_byte_o,
  output logic       miso_o
);

  logic       sck_q;
  logic [2:0] cnt_q;
  logic [7:0] rx_q;
  logic [7:0] tx_q;
  logic       miso_q;
  logic       rise;
  logic       fall;

  assign rise = sck_i & ~sck_q & ~cs_i;
  assign fall = ~sck_i & sck_q & ~cs_i;

  assign byte_done_o = rise & (cnt_q == 3'd7);
  assign rx_byte_o   = {rx_q[6:0], mosi_i};
  assign miso_o      = miso_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q  <= 1'b0;
      cnt_q  <= 3'd0;
      rx_q   <= 8'h00;
      tx_q   <= 8'h00;
      miso_q <= 1'b0;
    end else begin
      sck_q <= sck_i;
      if (clr_cnt_i) begin
        cnt_q <= 3'd0;
      end else if (rise) begin
        cnt_q <= cnt_q + 3'd1;
      end
      if (rise) begin
        rx_q <= {rx_q[6:0], mosi_i};
      end
      // The host samples on rise, so the next bit is presented on the fall before it.
      if (tx_load_i) begin
        tx_q <= tx_data_i;
      end else if (fall && shift_en_i) begin
        tx_q <= {tx_q[6:0], 1'b0};
      end
      if (cs_i || !shift_en_i) begin
        miso_q <= 1'b0;
      end else if (fall) begin
        miso_q <= tx_q[7];
      end
    end
  end

endmodule

// File: rtl/csr_spi_slave.sv
// SPI slave register file: decodes a command byte, then streams data bytes
// with auto-increment, committing writes to an 8-bit register bank.
module csr_spi_slave
  import csr_spi_slave_pkg::*;
#(
  parameter int         NUM_REGS    = NUM_REGS_DEF,
  parameter logic [6:0] STATUS_ADDR = STATUS_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  csr_spi_slave_if.slave        spi,
  input  logic [7:0]            status_in,
  output logic [NUM_REGS*8-1:0] csr_regs,
  output logic                  csr_wr_strobe,
  output logic [6:0]            csr_wr_addr,
  output logic [7:0]            csr_wr_data,
  output spi_state_e            dbg_state_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Write notification: csr_wr_strobe is a one-cycle valid with no ready;
  // csr_wr_addr/csr_wr_data are meaningful only while it is high.

  spi_state_e state_q, state_d;
  logic       cs_q;
  logic       wr_q;
  logic [6:0] addr_q;
  logic [7:0] regs_q [NUM_REGS];
  logic       strobe_q;
  logic [6:0] wr_addr_q;
  logic [7:0] wr_data_q;

  logic       byte_done;
  logic [7:0] rx_byte;
  logic       miso;
  logic       cs_fall;
  logic       cmd_done;
  logic       data_done;
  logic       wr_commit;
  logic [6:0] rd_addr;
  logic [7:0] rd_val;

  function automatic logic in_bank(input logic [6:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  // cs_q resets low so a transaction cut by reset is ignored until cs rises.
  assign cs_fall   = ~spi.spi_cs & cs_q;
  assign cmd_done  = byte_done && (state_q == ST_CMD);
  assign data_done = byte_done && (state_q == ST_DATA);
  assign wr_commit = data_done && wr_q && in_bank(addr_q) && (addr_q != STATUS_ADDR);
  assign rd_addr   = cmd_done ? rx_byte[6:0] : addr_q + 7'd1;

  always_comb begin
    rd_val = 8'h00;
    if (rd_addr == STATUS_ADDR) begin
      rd_val = status_in;
    end else if (in_bank(rd_addr)) begin
      rd_val = regs_q[rd_addr[IDX_W-1:0]];
    end
  end

  always_comb begin
    state_d = state_q;
    if (spi.spi_cs) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) state_d = ST_CMD;
        ST_CMD:  if (byte_done) state_d = ST_DATA;
        ST_DATA: state_d = ST_DATA;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cs_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= 7'd0;
      strobe_q  <= 1'b0;
      wr_addr_q <= 7'd0;
      wr_data_q <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      state_q  <= state_d;
      cs_q     <= spi.spi_cs;
      strobe_q <= wr_commit;
      if (cmd_done) begin
        wr_q   <= rx_byte[CMD_WR_BIT];
        addr_q <= rx_byte[6:0];
      end else if (data_done) begin
        addr_q <= addr_q + 7'd1;
      end
      if (wr_commit) begin
        regs_q[addr_q[IDX_W-1:0]] <= rx_byte;
        wr_addr_q                 <= addr_q;
        wr_data_q                 <= rx_byte;
      end
    end
  end

  csr_spi_slave_edge_shift u_edge_shift (
    .clk        (clk),
    .rst        (rst),
    .cs_i       (spi.spi_cs),
    .sck_i      (spi.spi_sck),
    .mosi_i     (spi.spi_mosi),
    .clr_cnt_i  (state_q == ST_IDLE),
    .shift_en_i (state_q == ST_DATA),
    .tx_load_i  (cmd_done | data_done),
    .tx_data_i  (rd_val),
    .byte_done_o(byte_done),
    .rx_byte_o  (rx_byte),
    .miso_o     (miso)
  );

  assign spi.spi_miso = miso;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign csr_regs[8*g +: 8] = regs_q[g];
  end

  assign csr_wr_strobe = strobe_q;
  assign csr_wr_addr   = wr_addr_q;
  assign csr_wr_data   = wr_data_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_csr_spi_slave.sv
// Directed bench for csr_spi_slave: SPI mode-0 host driver, register-bank
// model, strobe scoreboard and a one-line summary.
module tb_csr_spi_slave;
  import csr_spi_slave_pkg::*;

  logic         clk;
  logic         rst;
  logic [7:0]   status_in;
  logic [127:0] csr_regs;
  logic         csr_wr_strobe;
  logic [6:0]   csr_wr_addr;
  logic [7:0]   csr_wr_data;
  spi_state_e   dbg_state;

  csr_spi_slave_if spi_bus ();

  csr_spi_slave dut (
    .clk          (clk),
    .rst          (rst),
    .spi          (spi_bus),
    .status_in    (status_in),
    .csr_regs     (csr_regs),
    .csr_wr_strobe(csr_wr_strobe),
    .csr_wr_addr  (csr_wr_addr),
    .csr_wr_data  (csr_wr_data),
    .dbg_state_o  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int strobe_cnt = 0;
  logic [14:0] exp_q[$];
  logic [7:0]  m_regs[16];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < 16; i++) f[8*i +: 8] = m_regs[i];
    return f;
  endfunction

  // Scoreboard: every strobe must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (csr_wr_strobe) begin
      strobe_cnt++;
      if (exp_q.size() > 0) begin
        logic [14:0] e;
        e = exp_q.pop_front();
        check("strobe_addr_data", 128'({csr_wr_addr, csr_wr_data}), 128'(e));
      end
    end
  end

  // Driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    spi_bus.spi_cs = 1'b0;
    wait_clks(4);
  endtask

  task automatic cs_high();
    wait_clks(4);
    spi_bus.spi_cs = 1'b1;
    wait_clks(6);
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_bus.spi_mosi = tx[7-i];
      wait_clks(4);
      rx[7-i] = spi_bus.spi_miso;
      spi_bus.spi_sck = 1'b1;
      wait_clks(4);
      spi_bus.spi_sck = 1'b0;
    end
  endtask

  task automatic expect_write(input logic [6:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
    m_regs[a[3:0]] = d;
  endtask

  task automatic write_one(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] rx;
    cs_low();
    spi_xfer({1'b1, a}, 8, rx);
    if (a < 7'd16) expect_write(a, d);
    spi_xfer(d, 8, rx);
    cs_high();
  endtask

  task automatic read_one(input logic [6:0] a, output logic [7:0] rd);
    logic [7:0] rx;
    cs_low();
    spi_xfer({1'b0, a}, 8, rx);
    spi_xfer(8'h00, 8, rd);
    cs_high();
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] rd;
    int s0;

    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    rst = 1'b1;
    status_in = 8'h00;
    spi_bus.spi_cs = 1'b1;
    spi_bus.spi_sck = 1'b0;
    spi_bus.spi_mosi = 1'b0;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2);

    check("reset_regs", csr_regs, 128'h0);
    check("reset_miso", 128'(spi_bus.spi_miso), 128'h0);
    check("reset_strobe", 128'(csr_wr_strobe), 128'h0);
    check("reset_wr_addr_data", 128'({csr_wr_addr, csr_wr_data}), 128'h0);
    check("reset_state", 128'(dbg_state), 128'(ST_IDLE));

    // Single write 83, A5
    s0 = strobe_cnt;
    cs_low();
    spi_xfer(8'h83, 8, rx);
    check("cmd_miso_zero", 128'(rx), 128'h0);
    expect_write(7'd3, 8'hA5);
    spi_xfer(8'hA5, 8, rx);
    cs_high();
    check("single_regs", csr_regs, model_flat());
    check("single_strobes", 128'(strobe_cnt - s0), 128'd1);

    // Burst 8E: 11, 22 land in 14, 15; address 16 ignored
    s0 = strobe_cnt;
    cs_low();
    spi_xfer(8'h8E, 8, rx);
    expect_write(7'd14, 8'h11);
    spi_xfer(8'h11, 8, rx);
    expect_write(7'd15, 8'h22);
    spi_xfer(8'h22, 8, rx);
    spi_xfer(8'h33, 8, rx);
    cs_high();
    check("burst_regs", csr_regs, model_flat());
    check("burst_strobes", 128'(strobe_cnt - s0), 128'd2);

    // Read back reg[5] = 3C
    write_one(7'd5, 8'h3C);
    s0 = strobe_cnt;
    read_one(7'd5, rd);
    check("read_reg5", 128'(rd), 128'h3C);
    check("read_no_strobe", 128'(strobe_cnt - s0), 128'd0);
    read_one(7'd14, rd);
    check("read_reg14", 128'(rd), 128'h11);
    read_one(7'h20, rd);
    check("read_unmapped", 128'(rd), 128'h0);

    // Status read and write protection
    status_in = 8'h81;
    read_one(7'h7F, rd);
    check("status_read", 128'(rd), 128'h81);
    s0 = strobe_cnt;
    cs_low();
    spi_xfer(8'hFF, 8, rx);
    spi_xfer(8'h55, 8, rx);
    cs_high();
    check("status_rbw", 128'(rx), 128'h81);
    check("status_wr_no_strobe", 128'(strobe_cnt - s0), 128'd0);
    check("status_wr_regs", csr_regs, model_flat());
    read_one(7'h7F, rd);
    check("status_reread", 128'(rd), 128'h81);

    // Read-before-write returns the prior value of reg[3]
    cs_low();
    spi_xfer(8'h83, 8, rx);
    expect_write(7'd3, 8'h5C);
    spi_xfer(8'h5C, 8, rx);
    cs_high();
    check("rbw_prior", 128'(rx), 128'hA5);

    // Read burst wrapping 7E -> 7F (status) -> 00
    write_one(7'd0, 8'h5A);
    cs_low();
    spi_xfer(8'h7E, 8, rx);
    spi_xfer(8'h00, 8, rx);
    check("wrap_7e", 128'(rx), 128'h0);
    spi_xfer(8'h00, 8, rx);
    check("wrap_7f", 128'(rx), 128'h81);
    spi_xfer(8'h00, 8, rx);
    check("wrap_00", 128'(rx), 128'h5A);
    cs_high();

    // Abort mid-byte
    s0 = strobe_cnt;
    cs_low();
    spi_xfer(8'h82, 8, rx);
    spi_xfer(8'hF8, 5, rx);
    cs_high();
    check("abort_regs", csr_regs, model_flat());
    check("abort_no_strobe", 128'(strobe_cnt - s0), 128'd0);
    write_one(7'd2, 8'h44);
    check("after_abort_regs", csr_regs, model_flat());

    // Reset in the middle of a data byte
    write_one(7'd1, 8'h77);
    check("pre_reset_regs", csr_regs, model_flat());
    s0 = strobe_cnt;
    cs_low();
    spi_xfer(8'h81, 8, rx);
    spi_xfer(8'hC3, 4, rx);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    check("midreset_regs", csr_regs, 128'h0);
    check("midreset_miso", 128'(spi_bus.spi_miso), 128'h0);
    spi_xfer(8'h30, 4, rx);
    check("midreset_state", 128'(dbg_state), 128'(ST_IDLE));
    cs_high();
    check("midreset_no_strobe", 128'(strobe_cnt - s0), 128'd0);
    check("midreset_regs_after", csr_regs, 128'h0);
    write_one(7'd1, 8'h99);
    check("post_reset_regs", csr_regs, model_flat());
    read_one(7'd1, rd);
    check("post_reset_read", 128'(rd), 128'h99);

    wait_clks(4);
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csr_spi_slave.md
Name: csr_spi_slave

Overview:
- SPI slave control/status register file; sits directly upstream of the EPD controller (caster) in the clk_epdc domain.
- Consumes the already double-flop-synchronised spi_cs/spi_sck/spi_mosi lines, drives spi_miso, and exposes an 8-bit register bank plus a write strobe.
- Replaces the hard-tied power/status path: the host writes configuration and reads back controller status.

Parameters:
- NUM_REGS, 16: number of 8-bit read/write registers, addresses 0..NUM_REGS-1.
- STATUS_ADDR, 7'h7F: read-only address that returns status_in; writes to it are ignored.

Ports:
- clk  input  1  system clock; must be at least 4x the SPI SCK frequency.
- rst  input  1  synchronous, active-high reset.
- spi_cs  input  1  chip select, active low, pre-synchronised to clk.
- spi_sck  input  1  SPI clock (mode 0), pre-synchronised.
- spi_mosi  input  1  host data in, pre-synchronised.
- spi_miso  output  1  host data out.
- status_in  input  8  live status word (e.g. {pok, calib_done, error, ...}).
- csr_regs  output  NUM_REGS*8  flat register bank; reg[i] occupies bits [8i+7:8i].
- csr_wr_strobe  output  1  one-cycle pulse per committed register write.
- csr_wr_addr  output  7  address of the committed write, valid with the strobe.
- csr_wr_data  output  8  data of the committed write, valid with the strobe.

Behaviour:
- Edge detect: sck_q registers spi_sck. rise = spi_sck & ~sck_q; fall = ~spi_sck & sck_q. Both are qualified by spi_cs==0.
- FSM states:
  - IDLE: entered from reset or while cs is high.
  - CMD: shifting the command byte.
  - DATA: shifting data bytes.
  - Transitions: IDLE->CMD when cs falls. CMD->DATA on the 8th rise. DATA->DATA after every 8 rises. Any state->IDLE when cs is high.
- Bit counter: 3 bits, increments on each rise, cleared in IDLE.
- rx_shift: on each rise, rx_shift <= {rx_shift[6:0], spi_mosi}.
- Command byte: bit7 = write flag (1 = write), bits[6:0] = start address. Both are latched on the 8th rise of CMD.
- Read data load: on the rise that completes the CMD byte, and on every rise that completes a DATA byte, tx_shift loads rdval(addr_next).
  - addr_next is the latched address for the first data byte, then the auto-incremented address.
  - rdval(a) = status_in if a==STATUS_ADDR; reg[a] if a<NUM_REGS; else 8'h00.
- MISO: on each fall while in DATA, spi_miso <= tx_shift[7] and tx_shift <= tx_shift<<1.
  - spi_miso is 0 in IDLE and CMD, and is forced to 0 the cycle after cs goes high.
- Write commit: on the rise that completes a DATA byte, with write flag set:
  - if addr<NUM_REGS and addr!=STATUS_ADDR: reg[addr] <= {rx_shift[6:0], spi_mosi}, and csr_wr_strobe=1 for exactly one cycle (the next cycle) with addr/data.
  - otherwise: no write and no strobe.
- Latency: csr_regs updates 1 clk after the completing SCK rise is seen on the synchronised input.
- Auto-increment: address increments by 1 after each completed DATA byte, 7-bit wrap (7F->00).
- cs deassert mid-byte: partial byte discarded, no write, no strobe. Registers already committed are kept.
- rst: overrides every other event in the same cycle.
  - All regs 0, FSM IDLE, counters 0, spi_miso 0, csr_wr_strobe 0, csr_wr_addr 0, csr_wr_data 0.
  - Reset mid-transaction aborts it; the host must raise cs before the next transaction is decoded correctly. The FSM waits for cs high before re-entering CMD.
- Read-in-write: during write transactions MISO still shifts out the prior value of each addressed register (read-before-write).

Decomposition:
- Shared package (csr_pkg): register address constants (e.g. CSR_CTRL=0, CSR_VCOM=1, ...), STATUS_ADDR, the command-byte write bit index, and the field layout of status_in.
- One natural sub-module: spi_edge_shift (edge detect, bit counter, rx/tx shift registers, MISO drive). The top of the block holds the FSM, address logic and register bank.

Test Plan:
- Write single: cs low, send 8'h83 then 8'hA5, cs high → reg[3]=A5, one strobe with addr=3, data=A5; all other regs remain 0.
- Burst write with wrap: send 8'h8E then 11,22,33 (NUM_REGS=16) → reg[14]=11, reg[15]=22; address 16 ignored, no third strobe; exactly 2 strobes.
- Read back: preload reg[5]=3C, send 8'h05 then 8'h00 → MISO shifts 0,0,1,1,1,1,0,0 MSB first; no strobe.
- Status read/write-protect: status_in=8'h81; send 8'h7F,8'h00 → MISO returns 81. Then send 8'hFF,8'h55 → no strobe; a subsequent read still returns 81.
- Abort: send 8'h82 and 5 bits of data, raise cs → reg[2] unchanged, no strobe. The next full transaction 8'h82,8'h44 → reg[2]=44.
- Reset mid-burst: assert rst for 1 cycle during the data byte of a write to reg[1] (previously 77) → all regs 0, spi_miso 0, no strobe. After cs high then a new write, normal operation resumes.
